// File: rtl/morse_char_scheduler.sv
// morse_char_scheduler: filters PS/2 set-2 bytes down to make codes and queues them
// for the Morse encoder behind a valid/ready output stage.
module morse_char_scheduler #(
  parameter int         DEPTH          = 8,
  parameter logic [7:0] BACKSPACE_CODE = 8'h66
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               ps2_received_data,
  input  logic                     ps2_received_data_strb,
  input  logic                     flush,
  input  logic                     enc_ready,
  output logic [7:0]               enc_data,
  output logic                     enc_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} pstate_t;
  pstate_t         state_q, state_d;
  logic [7:0]      last_make_q, last_make_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      enc_data_q, enc_data_d;
  logic            enc_valid_q, enc_valid_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      b;
  logic            pop, is_make, rep, mk, bs, full, push;
  always_comb begin
    b           = ps2_received_data;
    full        = count_q == CW'(DEPTH);
    pop         = (count_q != '0) && (!enc_valid_q || enc_ready);
    is_make     = ps2_received_data_strb && state_q == IDLE && b != 8'hF0 && b != 8'hE0;
    rep         = b == last_make_q;
    mk          = is_make && !rep && b != BACKSPACE_CODE;
    push        = mk && (!full || pop);
    // a lone entry being popped this cycle is already committed to the output stage
    bs          = is_make && !rep && b == BACKSPACE_CODE && count_q != '0 && !(pop && count_q == CW'(1));
    state_d     = state_q;
    last_make_d = last_make_q;
    if (ps2_received_data_strb)
      case (state_q)
        IDLE: begin
          state_d = b == 8'hF0 ? BRK : b == 8'hE0 ? EXT : IDLE;
          if (is_make) last_make_d = b;
        end
        BRK: begin
          state_d = IDLE;
          if (b == last_make_q) last_make_d = '0;
        end
        EXT:     state_d = b == 8'hF0 ? EXT_BRK : b == 8'hE0 ? EXT : IDLE;
        EXT_BRK: state_d = IDLE;
      endcase
    wr_ptr_d    = wr_ptr_q + AW'(push) - AW'(bs);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop) - CW'(bs);
    enc_valid_d = pop || (enc_valid_q && !enc_ready);
    enc_data_d  = pop ? mem[rd_ptr_q] : enc_data_q;
    overflow_d  = overflow_q || (mk && full && !pop);
    if (flush) begin
      state_d     = IDLE;
      last_make_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      enc_valid_d = 1'b0;
      enc_data_d  = '0;
      overflow_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      last_make_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      enc_valid_q <= 1'b0;
      enc_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_make_q <= last_make_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enc_valid_q <= enc_valid_d;
      enc_data_q  <= enc_data_d;
      overflow_q  <= overflow_d;
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr_q] <= b;
  assign enc_data   = enc_data_q;
  assign enc_valid  = enc_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
endmodule
